// File: rtl/alu_mul_seq.sv
// Shift-add 32x32->64 multiply sequencer that borrows the shared ALU once per iteration.
// Define MUL_SIGNED_EN to add signed_i and the FIXA/FIXB two's-complement correction steps.
module alu_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
`ifdef MUL_SIGNED_EN
  input  logic            signed_i,
`endif
  input  logic [XLEN-1:0] mcand,
  input  logic [XLEN-1:0] mplier,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] prod_hi,
  output logic [XLEN-1:0] prod_lo,
  output logic            zero,
  output logic [5:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic            alu_ci,
  input  logic [XLEN-1:0] alu_y,
  input  logic            alu_c
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [5:0] OP_PASS_A = 6'b100000;
  localparam logic [5:0] OP_ADDCC  = 6'b010000;
  localparam logic [5:0] OP_SUBCC  = 6'b010100;

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIXA, FIXB} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t             state_q, state_d;
  logic [XLEN-1:0]    m_q, m_d;
  logic [XLEN-1:0]    phi_q, phi_d;
  logic [XLEN-1:0]    plo_q, plo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               zero_q, zero_d;
  logic [XLEN-1:0]    prod_hi_q, prod_hi_d;
  logic [XLEN-1:0]    prod_lo_q, prod_lo_d;
  logic [2*XLEN-1:0]  shifted;
  logic               carry;
`ifdef MUL_SIGNED_EN
  logic [XLEN-1:0]    mplr_q, mplr_d;
  logic               signed_q, signed_d;
  logic [XLEN-1:0]    fix_hi;
`endif

  assign alu_ci = 1'b0;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    m_d       = m_q;
    phi_d     = phi_q;
    plo_d     = plo_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    zero_d    = zero_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    alu_op    = OP_PASS_A;
    alu_a     = '0;
    alu_b     = '0;
    carry     = 1'b0;
    shifted   = '0;
`ifdef MUL_SIGNED_EN
    mplr_d    = mplr_q;
    signed_d  = signed_q;
    fix_hi    = phi_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = mcand;
          plo_d   = mplier;
          phi_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef MUL_SIGNED_EN
          mplr_d   = mplier;
          signed_d = signed_i;
`endif
        end
      end

      RUN: begin
        alu_a = phi_q;
        if (plo_q[0]) begin
          alu_op = OP_ADDCC;
          alu_b  = m_q;
          carry  = alu_c;
        end
        // Partial-product bit 0 falls off the bottom; the add carry enters at the top.
        shifted = {carry, alu_y, plo_q[XLEN-1:1]};
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          {phi_d, plo_d} = shifted;
          cnt_d          = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
`ifdef MUL_SIGNED_EN
            if (signed_q) begin
              state_d = FIXA;
            end else begin
              {prod_hi_d, prod_lo_d} = shifted;
              zero_d  = (shifted == '0);
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
`else
            {prod_hi_d, prod_lo_d} = shifted;
            zero_d  = (shifted == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`endif
          end
        end
      end

`ifdef MUL_SIGNED_EN
      FIXA: begin
        alu_a = phi_q;
        if (m_q[XLEN-1]) begin
          alu_op = OP_SUBCC;
          alu_b  = mplr_q;
          phi_d  = alu_y;
        end
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = FIXB;
        end
      end

      FIXB: begin
        alu_a = phi_q;
        if (mplr_q[XLEN-1]) begin
          alu_op = OP_SUBCC;
          alu_b  = m_q;
          fix_hi = alu_y;
        end
        state_d = IDLE;
        busy_d  = 1'b0;
        if (!abort) begin
          phi_d     = fix_hi;
          prod_hi_d = fix_hi;
          prod_lo_d = plo_q;
          zero_d    = ({fix_hi, plo_q} == '0);
          done_d    = 1'b1;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      phi_q     <= '0;
      plo_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
`ifdef MUL_SIGNED_EN
      mplr_q    <= '0;
      signed_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      phi_q     <= phi_d;
      plo_q     <= plo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
`ifdef MUL_SIGNED_EN
      mplr_q    <= mplr_d;
      signed_q  <= signed_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign zero    = zero_q;
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        signed_i;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        zero;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_ci;
  logic [31:0] alu_y;
  logic        alu_c;
  logic [32:0] alu_sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference ALU: pass A, ADDcc with carry out, SUBcc.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
  always_comb begin
    alu_y = 32'd0;
    alu_c = 1'b0;
    case (alu_op)
      6'b100000: alu_y = alu_a;
      6'b010000: begin
        alu_y = alu_sum[31:0];
        alu_c = alu_sum[32];
      end
      6'b010100: alu_y = alu_a - alu_b;
      default:   alu_y = 32'd0;
    endcase
  end

  alu_mul_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
`ifdef MUL_SIGNED_EN
    .signed_i(signed_i),
`endif
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .zero    (zero),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ci  (alu_ci),
    .alu_y   (alu_y),
    .alu_c   (alu_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one start request; returns 1 ns after the accepting edge.
  task automatic start_op(input logic [31:0] mc, input logic [31:0] mp, input logic sg);
    mcand    = mc;
    mplier   = mp;
    signed_i = sg;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    mcand    = 32'hDEAD_BEEF;
    mplier   = 32'hCAFE_F00D;
  endtask

  // Waits for done with a cycle budget and checks the edge count from acceptance.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cycles = 0;
    while (!done && cycles < 200) begin
      tick();
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
  endtask

  initial begin
    int bad_op;
    int seen_done;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    signed_i = 1'b0;
    mcand    = 32'd0;
    mplier   = 32'd0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_prod", {prod_hi, prod_lo}, 64'd0);
    check("rst_aluop", 64'(alu_op), 64'h20);
    check("rst_alua", {alu_a, alu_b}, 64'd0);
    reset = 1'b0;
    tick();

    // 8 * 7, with busy watched across the run and done as a single pulse
    start_op(32'd8, 32'd7, 1'b0);
    check("b2b0_busy_t0", 64'(busy), 64'd1);
    bad_op = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (!busy || done) bad_op++;
    end
    check("p1_busy_run", 64'(bad_op), 64'd0);
    tick();
    check("p1_done", 64'(done), 64'd1);
    check("p1_busy_end", 64'(busy), 64'd0);
    check("p1_prod", {prod_hi, prod_lo}, 64'h38);
    check("p1_zero", 64'(zero), 64'd0);
    tick();
    check("p1_done_pulse", 64'(done), 64'd0);

    // All-ones operands force the carry path on every add
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("p2", 32);
    check("p2_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFE_0000_0001);
    check("p2_zero", 64'(zero), 64'd0);
    tick();

    // Zero multiplicand: result zero, and the multiplier LSBs still drive add cycles
    start_op(32'd0, 32'h1234_5678, 1'b0);
    bad_op = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy && alu_op !== 6'b100000 && alu_op !== 6'b010000) bad_op++;
      tick();
    end
    check("p3_aluop", 64'(bad_op), 64'd0);
    check("p3_prod", {prod_hi, prod_lo}, 64'd0);
    check("p3_zero", 64'(zero), 64'd1);
    check("p3_done", 64'(done), 64'd1);
    tick();

    // Ignored restart mid-run, then back-to-back start in the done cycle
    start_op(32'd8, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    mcand  = 32'd3;
    mplier = 32'd4;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_done("p4", 26);
    check("p4_prod", {prod_hi, prod_lo}, 64'd56);
    start_op(32'd5, 32'd6, 1'b0);
    check("p5_busy", 64'(busy), 64'd1);
    wait_done("p5", 32);
    check("p5_prod", {prod_hi, prod_lo}, 64'd30);
    tick();

    // Abort mid-run keeps the previous product and emits no done
    start_op(32'd3, 32'd9, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen_done++;
      tick();
    end
    check("ab_nodone", 64'(seen_done), 64'd0);
    check("ab_prod", {prod_hi, prod_lo}, 64'd30);

    // Abort coinciding with the final iteration wins
    start_op(32'd11, 32'd13, 1'b0);
    for (int i = 0; i < 31; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abl_done", {63'd0, done}, 64'd0);
    check("abl_busy", 64'(busy), 64'd0);
    check("abl_prod", {prod_hi, prod_lo}, 64'd30);

    // start with abort high in IDLE is accepted
    abort = 1'b1;
    start_op(32'd100, 32'd200, 1'b0);
    abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd1);
    wait_done("sa", 32);
    check("sa_prod", {prod_hi, prod_lo}, 64'd20000);
    tick();

    // Asynchronous reset mid-run clears outputs before the next edge
    start_op(32'd7, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_prod", {prod_hi, prod_lo}, 64'd0);
    check("ar_flags", {62'd0, done, zero}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef MUL_SIGNED_EN
    start_op(32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_done("sg", 34);
    check("sg_prod", {prod_hi, prod_lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    tick();
    start_op(32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done("sg0", 32);
    check("sg0_prod", {prod_hi, prod_lo}, 64'h2_FFFF_FFFA);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
